// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the 16-bit processor control logic.
// Contents:
//   - opcode values (OP_RTYPE..OP_SW); OP_LAST is the highest legal opcode
//   - ALU operation codes driven on alu_op
//   - FSM state encoding of the multi-cycle control unit
//   - one-hot instruction class produced by the opcode decoder
package cpu_pkg;

   localparam int OP_RTYPE = 0;
   localparam int OP_ADDI  = 1;
   localparam int OP_ANDI  = 2;
   localparam int OP_ORI   = 3;
   localparam int OP_NORI  = 4;
   localparam int OP_BEQ   = 5;
   localparam int OP_BNE   = 6;
   localparam int OP_SLTI  = 7;
   localparam int OP_LW    = 8;
   localparam int OP_SW    = 9;
   localparam int OP_LAST  = 9;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_NOR = 3'b101;
   localparam logic [2:0] ALU_AND = 3'b110;
   localparam logic [2:0] ALU_OR  = 3'b111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Exactly one bit set for a legal opcode, all zero for an illegal one.
   typedef struct packed {
      logic rtype;    // register-register ALU
      logic alu_imm;  // addi/andi/ori/nori/slti
      logic branch;   // beq/bne
      logic load;     // lw
      logic store;    // sw
   } inst_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/memory bundle of the multi-cycle control unit.
// Memory handshake: the unit holds mem_read (fetch or lw) or mem_write (sw)
// high for as long as the access is outstanding; the memory raises mem_ready
// in the cycle the access completes. A mem_ready seen while stall=1 is not
// taken, so the memory must raise it again after stall drops.
// Modports:
//   slave  - the control unit (inputs opcode/mem_ready/stall, drives the rest)
//   master - the environment (instruction register, datapath, memory)
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 4,
   parameter int ALUOP_W  = 3,
   parameter int CNT_W    = 16
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                stall;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                pc_write;
   logic                branch;
   logic                branch_ne;
   logic                reg_dest;
   logic                alu_src;
   logic [ALUOP_W-1:0]  alu_op;
   logic                mem_to_reg;
   logic                reg_write;
   logic                illegal_op;
   logic                retire;
   logic [CNT_W-1:0]    retire_cnt;
   logic [2:0]          state;

   modport slave (
      input  opcode, mem_ready, stall,
      output mem_read, mem_write, ir_write, pc_write, branch, branch_ne,
             reg_dest, alu_src, alu_op, mem_to_reg, reg_write, illegal_op,
             retire, retire_cnt, state
   );

   modport master (
      output opcode, mem_ready, stall,
      input  mem_read, mem_write, ir_write, pc_write, branch, branch_ne,
             reg_dest, alu_src, alu_op, mem_to_reg, reg_write, illegal_op,
             retire, retire_cnt, state
   );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// mcu_opcode_decode: purely combinational opcode classifier, kept separate
// so a later pipelined control can reuse it.
// Ports:
//   op         in  opcode (registered copy in the multi-cycle unit)
//   cls        out one-hot instruction class (all zero when illegal)
//   is_illegal out opcode above OP_LAST
//   is_bne     out branch sense is "not equal"
//   alu_op     out ALU operation for this opcode
//   alu_src    out ALU operand B is the immediate
module mcu_opcode_decode
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ALUOP_W  = 3
) (
   input  logic [OPCODE_W-1:0] op,
   output inst_class_t         cls,
   output logic                is_illegal,
   output logic                is_bne,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                alu_src
);

   always_comb begin
      cls        = '0;
      is_bne     = 1'b0;
      alu_op     = ALUOP_W'(ALU_ADD);
      alu_src    = 1'b0;
      is_illegal = (op > OPCODE_W'(OP_LAST));
      case (op)
         OPCODE_W'(OP_RTYPE): cls.rtype = 1'b1;
         OPCODE_W'(OP_ADDI): begin
            cls.alu_imm = 1'b1;
            alu_src     = 1'b1;
         end
         OPCODE_W'(OP_ANDI): begin
            cls.alu_imm = 1'b1;
            alu_src     = 1'b1;
            alu_op      = ALUOP_W'(ALU_AND);
         end
         OPCODE_W'(OP_ORI): begin
            cls.alu_imm = 1'b1;
            alu_src     = 1'b1;
            alu_op      = ALUOP_W'(ALU_OR);
         end
         OPCODE_W'(OP_NORI): begin
            cls.alu_imm = 1'b1;
            alu_src     = 1'b1;
            alu_op      = ALUOP_W'(ALU_NOR);
         end
         OPCODE_W'(OP_BEQ): begin
            cls.branch = 1'b1;
            alu_op     = ALUOP_W'(ALU_SUB);
         end
         OPCODE_W'(OP_BNE): begin
            cls.branch = 1'b1;
            is_bne     = 1'b1;
            alu_op     = ALUOP_W'(ALU_SUB);
         end
         OPCODE_W'(OP_SLTI): begin
            cls.alu_imm = 1'b1;
            alu_src     = 1'b1;
            alu_op      = ALUOP_W'(ALU_SLT);
         end
         OPCODE_W'(OP_LW): begin
            cls.load = 1'b1;
            alu_src  = 1'b1;
         end
         OPCODE_W'(OP_SW): begin
            cls.store = 1'b1;
            alu_src   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: Moore FSM stepping each instruction through
// FETCH/DECODE/EXEC/MEM/WB against a shared instruction/data memory port.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  control/memory bundle (slave side); see multicycle_control_unit_if
// Outputs decode from state_q/op_q; the exceptions are the FETCH ir/pc write
// qualification and the sw retire in MEM, both of which follow mem_ready.
// stall freezes all state and suppresses every write-type output; rst
// overrides stall and blanks all outputs during the reset cycle.
module multicycle_control_unit
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ALUOP_W  = 3,
   parameter int CNT_W    = 16
) (
   input logic                     clk,
   input logic                     rst,
   multicycle_control_unit_if.slave bus
);

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    cnt_q;

   inst_class_t         cls;
   logic                dec_illegal;
   logic                dec_bne;
   logic [ALUOP_W-1:0]  dec_alu_op;
   logic                dec_alu_src;

   logic                mem_read, mem_write, ir_write, pc_write;
   logic                branch, branch_ne, reg_dest, alu_src;
   logic [ALUOP_W-1:0]  alu_op;
   logic                mem_to_reg, reg_write, illegal_op, retire;

   mcu_opcode_decode #(
      .OPCODE_W (OPCODE_W),
      .ALUOP_W  (ALUOP_W)
   ) u_decode (
      .op         (op_q),
      .cls        (cls),
      .is_illegal (dec_illegal),
      .is_bne     (dec_bne),
      .alu_op     (dec_alu_op),
      .alu_src    (dec_alu_src)
   );

   always_comb begin
      state_d    = state_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      reg_dest   = 1'b0;
      alu_src    = 1'b0;
      alu_op     = '0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               illegal_op = 1'b1;
               state_d    = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op   = dec_alu_op;
            alu_src  = dec_alu_src;
            reg_dest = cls.rtype;
            if (cls.branch) begin
               branch    = 1'b1;
               branch_ne = dec_bne;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end else if (cls.load || cls.store) begin
               state_d = S_MEM;
            end else if (cls.rtype || cls.alu_imm) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            alu_op    = dec_alu_op;
            alu_src   = dec_alu_src;
            mem_read  = cls.load;
            mem_write = cls.store;
            if (bus.mem_ready) begin
               if (cls.store) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            alu_op     = dec_alu_op;
            alu_src    = dec_alu_src;
            reg_write  = 1'b1;
            mem_to_reg = cls.load;
            reg_dest   = cls.rtype;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Stall freezes the FSM and suppresses anything that commits state.
      if (bus.stall) begin
         state_d    = state_q;
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         retire     = 1'b0;
         illegal_op = 1'b0;
      end

      // Reset cycle: nothing may start or complete.
      if (rst) begin
         state_d    = S_FETCH;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         branch     = 1'b0;
         branch_ne  = 1'b0;
         reg_dest   = 1'b0;
         alu_src    = 1'b0;
         alu_op     = '0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         illegal_op = 1'b0;
         retire     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (ir_write) op_q <= bus.opcode;
         if (retire)   cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.ir_write   = ir_write;
   assign bus.pc_write   = pc_write;
   assign bus.branch     = branch;
   assign bus.branch_ne  = branch_ne;
   assign bus.reg_dest   = reg_dest;
   assign bus.alu_src    = alu_src;
   assign bus.alu_op     = alu_op;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.reg_write  = reg_write;
   assign bus.illegal_op = illegal_op;
   assign bus.retire     = retire;
   assign bus.retire_cnt = cnt_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (counter width 4 so the
// wrap is reachable). Each instruction is expanded into a per-cycle list of
// phases (plus fetch/memory wait cycles and stall cycles) from the
// instruction's class; per-phase expected outputs come from the opcode map.
module tb_multicycle_control_unit;

   localparam int CW = 4;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [CW-1:0] exp_cnt;

   multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(CW)) bus ();

   multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(3), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [2:0] ref_alu(input logic [3:0] op);
      case (op)
         4'd5, 4'd6: return 3'b010;
         4'd7:       return 3'b100;
         4'd4:       return 3'b101;
         4'd2:       return 3'b110;
         4'd3:       return 3'b111;
         default:    return 3'b000;
      endcase
   endfunction

   // {state, mem_read, mem_write, ir_write, pc_write, branch, branch_ne,
   //  reg_dest, alu_src, alu_op[2:0], mem_to_reg, reg_write, illegal_op, retire}
   function automatic logic [17:0] exp_word(input int p, input logic [3:0] op,
                                            input bit r, input bit s);
      bit mr = 0, mw = 0, irw = 0, pcw = 0, br = 0, bne = 0, rd = 0, as = 0;
      bit m2r = 0, rw = 0, ill = 0, ret = 0;
      logic [2:0] ao = 3'b000;
      bit imm = (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9});
      bit isbr = (op == 4'd5) || (op == 4'd6);
      case (p)
         0: begin mr = 1; irw = r & ~s; pcw = r & ~s; end
         1: ill = (op > 4'd9) & ~s;
         2: begin
            ao = ref_alu(op); as = imm; rd = (op == 4'd0);
            br = isbr; bne = (op == 4'd6); ret = isbr & ~s;
         end
         3: begin
            ao = ref_alu(op); as = imm;
            mr = (op == 4'd8); mw = (op == 4'd9) & ~s;
            ret = (op == 4'd9) & r & ~s;
         end
         4: begin
            ao = ref_alu(op); as = imm; rw = ~s; m2r = (op == 4'd8);
            rd = (op == 4'd0); ret = ~s;
         end
         default: ;
      endcase
      return {3'(p), mr, mw, irw, pcw, br, bne, rd, as, ao, m2r, rw, ill, ret};
   endfunction

   function automatic logic [17:0] obs_word();
      return {bus.state, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
              bus.branch, bus.branch_ne, bus.reg_dest, bus.alu_src, bus.alu_op,
              bus.mem_to_reg, bus.reg_write, bus.illegal_op, bus.retire};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // One FETCH cycle with no memory response: state must be FETCH.
   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      bus.stall     = 1'b0;
      bus.opcode    = 4'($urandom_range(0, 15));
      @(negedge clk);
      check({tag, "_out"}, 32'(obs_word()), 32'(exp_word(0, 4'd0, 0, 0)));
      check({tag, "_cnt"}, 32'(bus.retire_cnt), 32'(exp_cnt));
   endtask

   // fw/mw: mem_ready-low cycles in FETCH/MEM; sn stall cycles placed before
   // the completing cycle of phase index sp; abort>=0 asserts rst on that cycle.
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                            input int sn, input int sp, input int abort);
      int ph[$];
      int cp[$];
      bit cr[$];
      bit cs[$];
      logic [17:0] e;
      ph.push_back(0);
      ph.push_back(1);
      if (op <= 4'd9) begin
         ph.push_back(2);
         if (op == 4'd8) begin ph.push_back(3); ph.push_back(4); end
         else if (op == 4'd9) ph.push_back(3);
         else if (op != 4'd5 && op != 4'd6) ph.push_back(4);
      end
      foreach (ph[i]) begin
         if (ph[i] == 0) repeat (fw) begin cp.push_back(0); cr.push_back(0); cs.push_back(0); end
         if (ph[i] == 3) repeat (mw) begin cp.push_back(3); cr.push_back(0); cs.push_back(0); end
         if (i == sp) repeat (sn) begin cp.push_back(ph[i]); cr.push_back(1); cs.push_back(1); end
         cp.push_back(ph[i]);
         cr.push_back((ph[i] == 0 || ph[i] == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
         cs.push_back(0);
      end
      foreach (cp[k]) begin
         @(posedge clk); #1;
         if (k == abort) rst = 1'b1;
         bus.opcode    = (cp[k] == 0 && cr[k] && !cs[k]) ? op : 4'($urandom_range(0, 15));
         bus.mem_ready = cr[k];
         bus.stall     = cs[k];
         @(negedge clk);
         if (k == abort) begin
            check("rst_cycle", 32'(obs_word()), {14'd0, 3'(cp[k]), 15'd0});
            @(posedge clk); #1;
            rst = 1'b0;
            exp_cnt = '0;
            bus.mem_ready = 1'b0;
            bus.stall     = 1'b0;
            @(negedge clk);
            check("after_rst_out", 32'(obs_word()), 32'(exp_word(0, 4'd0, 0, 0)));
            check("after_rst_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
            return;
         end
         e = exp_word(cp[k], op, cr[k], cs[k]);
         check($sformatf("op%0d_c%0d", op, k), 32'(obs_word()), 32'(e));
         check($sformatf("op%0d_c%0d_cnt", op, k), 32'(bus.retire_cnt), 32'(exp_cnt));
         if (e[0]) exp_cnt = exp_cnt + 1'b1;
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b1;
      bus.opcode = '0;
      bus.mem_ready = 1'b0;
      bus.stall = 1'b0;
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out", 32'(obs_word()), 32'd0);
      check("reset_cnt", 32'(bus.retire_cnt), 32'd0);
      rst = 1'b0;

      run_instr(4'd1, 0, 0, 0, -1, -1);   // addi: 0,1,2,4
      run_instr(4'd8, 0, 3, 0, -1, -1);   // lw with 3 memory wait cycles
      run_instr(4'd6, 0, 0, 0, -1, -1);   // bne
      run_instr(4'd12, 0, 0, 0, -1, -1);  // illegal
      run_instr(4'd9, 0, 0, 2, 3, -1);    // sw stalled 2 cycles in MEM
      run_instr(4'd5, 1, 0, 1, 0, -1);    // beq with fetch wait and fetch stall
      run_instr(4'd8, 0, 2, 0, -1, 4);    // lw reset during MEM wait

      for (int n = 0; n < 16; n++) run_instr(4'd0, 0, 0, 0, -1, -1);
      idle_check("wrap");
      check("wrap_zero", 32'(bus.retire_cnt), 32'd0);

      for (int n = 0; n < 40; n++)
         run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 4), -1);
      idle_check("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
